lcd_frame_sequencer: RTL and testbench

// Drives the ST7789V3 9-bit packet serializer ({rs,byte}) via valid/ready. After reset it

---
 rtl/lcd_frame_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer
//   Sole master of the ST7789V3 9-bit packet serializer ({rs,byte}, valid/ready).
//   After reset: pulse the panel hardware reset, play the init ROM (commands, data,
//   delays), then sit in IDLE. Each start emits the CASET/RASET/RAMWR window header
//   and streams WIDTH*HEIGHT RGB565 pixels, MSB byte first.
// Ports
//   clk, rst (async, active low)
//   start                         : begin one frame, honoured only in IDLE
//   px_valid/px_ready/px_data     : pixel source handshake (16b RGB565)
//   out_valid/out_ready/out_data  : serializer packet {rs, byte}
//   lcd_rst_n                     : panel hardware reset, active low
//   init_done, busy, frame_done   : status
// Build option
//   LCD_SEQ_DELAY_EN : real hardware-reset / init delays (DELAY_UNIT clk per tick).
//                      Undefined: every wait lasts one cycle (fast simulation).
module lcd_frame_sequencer #(
  parameter int WIDTH       = 240,
  parameter int HEIGHT      = 280,
  parameter int COL_OFFSET  = 0,
  parameter int ROW_OFFSET  = 20,
  parameter int DELAY_UNIT  = 12000,
  parameter int HWRST_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [15:0] px_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_data,
  output logic        lcd_rst_n,
  output logic        init_done,
  output logic        busy,
  output logic        frame_done
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PXW  = $clog2(NPIX + 1);
  localparam logic [PXW-1:0] PX_LAST = PXW'(NPIX - 1);
  localparam logic [15:0] COL_S = 16'(COL_OFFSET);
  localparam logic [15:0] COL_E = 16'(COL_OFFSET + WIDTH - 1);
  localparam logic [15:0] ROW_S = 16'(ROW_OFFSET);
  localparam logic [15:0] ROW_E = 16'(ROW_OFFSET + HEIGHT - 1);

  typedef enum logic [3:0] {
    HWRST, HWWAIT, ROM_FETCH, ROM_SEND, ROM_DELAY,
    IDLE, WIN_SEND, PIX_LOAD, PIX_HI, PIX_LO
  } state_t;

  // ROM entry {type[1:0], payload[7:0]}: 00 cmd, 01 data, 10 delay ticks, 11 end
  function automatic logic [9:0] rom_at(input logic [3:0] i);
    case (i)
      4'd0:    rom_at = 10'h001;
      4'd1:    rom_at = {2'b10, 8'd150};
      4'd2:    rom_at = 10'h011;
      4'd3:    rom_at = {2'b10, 8'd120};
      4'd4:    rom_at = 10'h03A;
      4'd5:    rom_at = 10'h155;
      4'd6:    rom_at = 10'h036;
      4'd7:    rom_at = 10'h100;
      4'd8:    rom_at = 10'h021;
      4'd9:    rom_at = 10'h013;
      4'd10:   rom_at = 10'h029;
      4'd11:   rom_at = {2'b10, 8'd20};
      default: rom_at = 10'h300;
    endcase
  endfunction

  function automatic logic [8:0] win_pkt(input logic [3:0] i);
    case (i)
      4'd0:    win_pkt = 9'h02A;
      4'd1:    win_pkt = {1'b1, COL_S[15:8]};
      4'd2:    win_pkt = {1'b1, COL_S[7:0]};
      4'd3:    win_pkt = {1'b1, COL_E[15:8]};
      4'd4:    win_pkt = {1'b1, COL_E[7:0]};
      4'd5:    win_pkt = 9'h02B;
      4'd6:    win_pkt = {1'b1, ROW_S[15:8]};
      4'd7:    win_pkt = {1'b1, ROW_S[7:0]};
      4'd8:    win_pkt = {1'b1, ROW_E[15:8]};
      4'd9:    win_pkt = {1'b1, ROW_E[7:0]};
      default: win_pkt = 9'h02C;
    endcase
  endfunction

  state_t         state, nxt;
  logic [3:0]     rom_idx, win_idx;
  logic [8:0]     rom_q;      // {rs, payload} of the entry being sent/waited on
  logic [9:0]     rom_rd;
  logic [15:0]    px_q;
  logic [PXW-1:0] px_cnt;
  logic           wait_done;
  logic           acc;
  logic           px_last;

  assign rom_rd  = rom_at(rom_idx);
  assign acc     = out_valid & out_ready;
  assign px_last = (px_cnt == PX_LAST);

`ifdef LCD_SEQ_DELAY_EN
  localparam int PRW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [PRW-1:0] PRE_MAX = PRW'(DELAY_UNIT - 1);
  logic [PRW-1:0] pre_cnt;
  logic [7:0]     tick_cnt, tick_tgt;
  logic           in_wait;

  always_comb begin
    tick_tgt = rom_q[7:0];
    if (state == HWRST)       tick_tgt = 8'(HWRST_TICKS);
    else if (state == HWWAIT) tick_tgt = 8'd120;
  end

  assign in_wait   = (state == HWRST) || (state == HWWAIT) || (state == ROM_DELAY);
  assign wait_done = (pre_cnt == PRE_MAX) && (tick_cnt == tick_tgt - 8'd1);

  // prescaler x tick counter, cleared whenever no wait is in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else if (!in_wait || wait_done) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt  <= '0;
      tick_cnt <= tick_cnt + 8'd1;
    end else begin
      pre_cnt  <= pre_cnt + 1'b1;
    end
  end
`else
  // fast-sim build: every wait collapses to one cycle
  logic unused_cfg;
  assign unused_cfg = ^{DELAY_UNIT, HWRST_TICKS};
  assign wait_done  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HWRST;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      HWRST:     if (wait_done) nxt = HWWAIT;
      HWWAIT:    if (wait_done) nxt = ROM_FETCH;
      ROM_FETCH: begin
        case (rom_rd[9:8])
          2'b00, 2'b01: nxt = ROM_SEND;
`ifdef LCD_SEQ_DELAY_EN
          2'b10:        nxt = (rom_rd[7:0] == 8'd0) ? ROM_FETCH : ROM_DELAY;
`else
          2'b10:        nxt = ROM_DELAY;
`endif
          default:      nxt = IDLE;
        endcase
      end
      ROM_SEND:  if (out_ready) nxt = ROM_FETCH;
      ROM_DELAY: if (wait_done) nxt = ROM_FETCH;
      IDLE:      if (start) nxt = WIN_SEND;
      WIN_SEND:  if (out_ready && win_idx == 4'd10) nxt = PIX_LOAD;
      PIX_LOAD:  if (px_valid) nxt = PIX_HI;
      PIX_HI:    if (out_ready) nxt = PIX_LO;
      PIX_LO:    if (out_ready) nxt = px_last ? IDLE : PIX_LOAD;
      default:   nxt = HWRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_idx    <= '0;
      rom_q      <= '0;
      win_idx    <= '0;
      px_q       <= '0;
      px_cnt     <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == PIX_LO) && out_ready && px_last;
      case (state)
        ROM_FETCH: begin
          rom_q <= rom_rd[8:0];
          if (rom_rd[9:8] == 2'b11) init_done <= 1'b1;
          else                      rom_idx   <= rom_idx + 4'd1;
        end
        IDLE: begin
          win_idx <= '0;
          px_cnt  <= '0;
        end
        WIN_SEND:  if (out_ready) win_idx <= win_idx + 4'd1;
        PIX_LOAD:  if (px_valid)  px_q    <= px_data;
        PIX_LO:    if (out_ready) px_cnt  <= px_last ? '0 : px_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // packets come from registers only, so data holds while the serializer stalls
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      ROM_SEND: begin out_valid = 1'b1; out_data = rom_q;               end
      WIN_SEND: begin out_valid = 1'b1; out_data = win_pkt(win_idx);    end
      PIX_HI:   begin out_valid = 1'b1; out_data = {1'b1, px_q[15:8]};  end
      PIX_LO:   begin out_valid = 1'b1; out_data = {1'b1, px_q[7:0]};   end
      default: ;
    endcase
  end

  assign px_ready  = (state == PIX_LOAD);
  assign lcd_rst_n = (state != HWRST);
  assign busy      = (state != IDLE);

  logic unused_acc;
  assign unused_acc = acc;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench for lcd_frame_sequencer.
//   dut_a: WIDTH=2, HEIGHT=1 (init ROM, pixel frames, random ready, reset mid-frame)
//   dut_b: default geometry (window header)
module tb_lcd_frame_sequencer;

`ifdef LCD_SEQ_DELAY_EN
  localparam int MIN_GAP = 600;
`else
  localparam int MIN_GAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        px_valid_a = 1'b0;
  logic [15:0] px_data_a  = 16'h0;
  logic        out_ready_a = 1'b1;
  logic        px_ready_a, px_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [8:0]  out_data_a, out_data_b;
  logic        lcd_rst_n_a, lcd_rst_n_b;
  logic        init_done_a, init_done_b;
  logic        busy_a, busy_b;
  logic        frame_done_a, frame_done_b;

  int checks = 0, failures = 0;
  int cyc = 0, fd_cnt = 0, t001 = 0, t011 = 0;
  bit rnd = 1'b0;
  logic [8:0]  qa[$], qb[$];
  logic [15:0] pxq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_frame_sequencer #(.WIDTH(2), .HEIGHT(1), .DELAY_UNIT(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .px_valid(px_valid_a), .px_ready(px_ready_a), .px_data(px_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .lcd_rst_n(lcd_rst_n_a), .init_done(init_done_a), .busy(busy_a),
    .frame_done(frame_done_a));

  lcd_frame_sequencer #(.DELAY_UNIT(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .px_valid(1'b0), .px_ready(px_ready_b), .px_data(16'h0),
    .out_valid(out_valid_b), .out_ready(1'b1), .out_data(out_data_b),
    .lcd_rst_n(lcd_rst_n_b), .init_done(init_done_b), .busy(busy_b),
    .frame_done(frame_done_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- drivers (inputs change 1 time unit after posedge)
  initial forever begin
    @(posedge clk); #1;
    out_ready_a = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  initial forever begin
    bit fire;
    @(negedge clk);
    fire = px_valid_a && px_ready_a;
    @(posedge clk); #1;
    if (fire && pxq.size() != 0) void'(pxq.pop_front());
    px_valid_a = (pxq.size() != 0);
    px_data_a  = (pxq.size() != 0) ? pxq[0] : 16'h0;
  end

  // ---------------- monitors
  initial forever begin
    logic [8:0] e;
    logic       stall;
    logic [8:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
      end else begin
        if (stall && out_valid_a) chk("a_stall_stable", out_data_a, held);
        stall = out_valid_a && !out_ready_a;
        held  = out_data_a;
        if (out_valid_a && out_ready_a) begin
          if (qa.size() == 0) chk("a_unexpected_pkt", out_data_a, 9'h1FF);
          else begin
            e = qa.pop_front();
            chk("a_pkt", out_data_a, e);
          end
          if (out_data_a == 9'h001) t001 = cyc;
          if (out_data_a == 9'h011) t011 = cyc;
          if (out_data_a == 9'h029) chk("a_init_done_before_last_delay", init_done_a, 1'b0);
        end
        if (frame_done_a) begin
          fd_cnt++;
          chk("a_frame_done_state_idle", busy_a, 1'b0);
        end
      end
    end
  end

  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (rst && out_valid_b) begin
      if (qb.size() == 0) chk("b_unexpected_pkt", out_data_b, 9'h1FF);
      else begin
        e = qb.pop_front();
        chk("b_pkt", out_data_b, e);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic push_init(input bit to_b);
    logic [8:0] v[9];
    v = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h100, 9'h021, 9'h013, 9'h029};
    foreach (v[i]) if (to_b) qb.push_back(v[i]); else qa.push_back(v[i]);
  endtask

  task automatic push_win_a();
    logic [8:0] v[11];
    v = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h114, 9'h100, 9'h114, 9'h02C};
    foreach (v[i]) qa.push_back(v[i]);
  endtask

  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_lcd_rst_n", lcd_rst_n_a, 1'b0);
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_out_data", out_data_a, 9'h0);
    chk("rst_px_ready", px_ready_a, 1'b0);
    chk("rst_init_done", init_done_a, 1'b0);
    chk("rst_busy", busy_a, 1'b1);
    chk("rst_frame_done", frame_done_a, 1'b0);
  endtask

  task automatic wait_init(input string nm);
    int k = 0;
    while (!(init_done_a && init_done_b) && k < 6000) begin @(negedge clk); k++; end
    chk(nm, {init_done_a, init_done_b}, 2'b11);
  endtask

  task automatic wait_empty(input string nm, input int n);
    int k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < n) begin @(negedge clk); k++; end
    chk(nm, qa.size() + qb.size(), 0);
  endtask

  task automatic wait_fd(input int target, input string nm);
    int k = 0;
    while (fd_cnt < target && k < 4000) begin @(negedge clk); k++; end
    chk(nm, fd_cnt, target);
  endtask

  // ---------------- sequence
  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();

    // init ROM replay; a start during init must be ignored
    push_init(1'b0);
    push_init(1'b1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    pulse_a();
    wait_init("init_done_rise");
    wait_empty("init_pkts_drained", 50);
    chk("init_gap_after_001", (t011 - t001) >= MIN_GAP, 1'b1);
    @(negedge clk);
    chk("idle_not_busy", busy_a, 1'b0);

    // default-geometry window header on dut_b
    foreach (qb[i]) ; // no-op, keeps queue ordering explicit
    qb.push_back(9'h02A); qb.push_back(9'h100); qb.push_back(9'h100);
    qb.push_back(9'h100); qb.push_back(9'h1EF); qb.push_back(9'h02B);
    qb.push_back(9'h100); qb.push_back(9'h114); qb.push_back(9'h101);
    qb.push_back(9'h12B); qb.push_back(9'h02C);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;

    // frame 1: two pixels, extra start mid-frame ignored
    push_win_a();
    qa.push_back(9'h1F8); qa.push_back(9'h100);
    qa.push_back(9'h107); qa.push_back(9'h1E0);
    pxq.push_back(16'hF800); pxq.push_back(16'h07E0);
    pulse_a();
    repeat (4) @(posedge clk);
    pulse_a();
    wait_fd(1, "frame1_done");
    chk("frame1_px_ready_idle", px_ready_a, 1'b0);
    repeat (30) @(negedge clk);
    chk("frame1_single_pulse", fd_cnt, 1);
    chk("frame1_back_idle", busy_a, 1'b0);
    wait_empty("frame1_drained", 10);

    // frame 2: serializer ready at ~30% duty
    rnd = 1'b1;
    push_win_a();
    qa.push_back(9'h112); qa.push_back(9'h134);
    qa.push_back(9'h1AB); qa.push_back(9'h1CD);
    pxq.push_back(16'h1234); pxq.push_back(16'hABCD);
    pulse_a();
    wait_fd(2, "frame2_done");
    rnd = 1'b0;
    wait_empty("frame2_drained", 10);

    // frame 3: source stalls after one pixel, then reset mid-frame
    push_win_a();
    qa.push_back(9'h155); qa.push_back(9'h155);
    pxq.push_back(16'h5555);
    pulse_a();
    wait_empty("frame3_partial_drained", 500);
    repeat (5) @(negedge clk);
    chk("stall_no_out_valid", out_valid_a, 1'b0);
    chk("stall_px_ready", px_ready_a, 1'b1);
    chk("stall_busy", busy_a, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset();
    push_init(1'b0);
    push_init(1'b1);
    @(posedge clk); #1 rst = 1'b1;
    wait_init("reinit_done");
    wait_empty("reinit_pkts_drained", 50);
    repeat (10) @(negedge clk);
    chk("no_frame_done_after_abort", fd_cnt, 2);
    chk("final_idle", busy_a, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
